quiz_key_debounce: RTL and testbench
====================================

# quiz_key_debounce

Input conditioning stage for the four-player quiz buzzer. It sits directly upstream of the answer judge: it takes the four raw active-low answer buttons and the raw start switch, synchronises and debounces each one, and drives clean active-high levels plus single-cycle press pulses. The judge consumes these as its `k1..k4` and `start` inputs.

## Interface
- `CLK_HZ`, default 12_000_000: system clock frequency in Hz.
- `DEBOUNCE_MS`, default 20: required stable time in ms.
- `SYNC_STAGES`, default 2: synchroniser depth; must be ≥2.
- `CNT_MAX`, derived as (CLK_HZ/1000)*DEBOUNCE_MS − 1: not overridable; must be ≥1.
- `clk`  in  1  system clock. One clock domain only; all logic on its rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `key_n`  in  4  raw answer buttons, active-low (0 = pressed). Asynchronous to `clk`.
- `start_sw`  in  1  raw start switch, active-high (1 = quiz armed). Asynchronous to `clk`.
- `k`  out  4  debounced button levels, active-high (1 = pressed). `k[0]` maps to judge `k1`.
- `k_press`  out  4  one-cycle pulse when the matching `k` bit goes 0→1.
- `start`  out  1  debounced start level.
- `start_rise`  out  1  one-cycle pulse when `start` goes 0→1.

## Operation
- There are five identical, independent channels: four keys (raw inverted at the input) and start.
- Per channel:
  - Synchroniser: a chain of SYNC_STAGES flops driving `s`.
  - Stable register: `q`.
  - Counter: `cnt`, width $clog2(CNT_MAX+1).
- Behaviour at each edge:
  - If `s == q`: `cnt` ← 0.
  - If `s != q` and `cnt != CNT_MAX`: `cnt` ← `cnt` + 1.
  - If `s != q` and `cnt == CNT_MAX`: `q` ← `s`, `cnt` ← 0, and the edge pulse asserts for that one cycle, only when the new `q` is 1.
- Glitch rejection: any mismatch that lasts fewer than CNT_MAX+1 cycles at `s` resets `cnt` and leaves `q` unchanged.
- Release (1→0) updates the level output only; no pulse is generated on release.
- Pulses are registered and align with the cycle in which the level output first reads 1.
- Simultaneous presses on several keys produce simultaneous `k_press` bits. No arbitration is done here; priority belongs to the judge.
- The counter never wraps: it saturates at CNT_MAX and resolves on that same edge.

## Timing
- Reset values (asserted asynchronously; held while `rst` = 1):
  - All synchroniser flops = idle (key: released, start: 0).
  - `q` = 0 and `cnt` = 0.
  - `k` = 4'b0000, `k_press` = 0, `start` = 0, `start_rise` = 0.
- Latency: a raw change held steady reaches the output exactly SYNC_STAGES + CNT_MAX + 1 rising edges after the edge that first samples it.
- Reset mid-press: the channel returns to released. If the key is still held after `rst` falls, it is re-detected as a fresh press after the full latency and produces one `k_press`.
- Pulse width is exactly one cycle. Pulses on the same channel are separated by at least 2·(CNT_MAX+1) cycles.

## Structure
- Shared package `quiz_pkg`:
  - `NUM_KEYS` = 4.
  - A function computing CNT_MAX from CLK_HZ and DEBOUNCE_MS.
  - A counter-width function (clog2).
- Sub-module `debounce_ch`:
  - Parameters: SYNC_STAGES, CNT_MAX, INVERT.
  - Ports: `clk`, `rst`, `raw`, `level`, `rise`.
- The top level instantiates `debounce_ch` five times: keys with INVERT = 1, start with INVERT = 0.

## Test plan
All scenarios use CLK_HZ = 1000 and DEBOUNCE_MS = 4, giving CNT_MAX = 3 and a latency of 6 edges.
- Reset check: assert `rst` asynchronously between edges with all keys held low. All outputs must read 0 immediately and stay 0 while `rst` is high.
- Clean press: drive `key_n[2]` 1→0 and hold. `k[2]` must rise on edge 6, with `k_press[2]` high for that single cycle. `k` then stays 4'b0100.
- Glitch rejection: pulse `key_n[0]` low for 3 cycles, then high. `k[0]` and `k_press[0]` must stay 0 throughout, and `cnt` must return to 0.
- Bounce then settle: toggle `key_n[1]` every 2 cycles for 10 cycles, then hold low. Exactly one `k_press[1]` must occur, 6 edges after the final settle.
- Simultaneous press and release: drop `key_n[0]` and `key_n[3]` on the same cycle. `k_press` must read 4'b1001 for one cycle. On release, `k` must clear 6 edges later with no pulse.
- Start and reset mid-press:
  - Raise `start_sw`: `start` and a single `start_rise` must follow after 6 edges.
  - Pulse `rst` while `key_n[1]` is held: a new `k_press[1]` must appear 6 edges after `rst` falls.

Source files
------------

// File: rtl/quiz_pkg.sv
// Shared constants and helpers for the quiz buzzer input stage.
// Derives the debounce counter limit and width from clock and stable time.
package quiz_pkg;

  localparam int NUM_KEYS = 4;

  function automatic int calc_cnt_max(input int clk_hz, input int debounce_ms);
    return (clk_hz / 1000) * debounce_ms - 1;
  endfunction

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) < (max_val + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser chain, stable level register and
// saturating stability counter, with a registered 0->1 pulse.
module debounce_ch
  import quiz_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 3,
  parameter bit INVERT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = cnt_width(CNT_MAX);

  logic                   raw_i;
  logic                   s;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   q_q, q_d;
  logic                   rise_q, rise_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Active-low keys are inverted up front so every flop idles at 0.
  assign raw_i = INVERT ? ~raw : raw;
  assign s     = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    q_d    = q_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    // The counter saturates at CNT_MAX and the new level is taken on that same edge.
    if (s != q_q) begin
      if (cnt_q == CNT_W'(CNT_MAX)) begin
        q_d    = s;
        rise_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      q_q    <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
    end
  end

  assign level = q_q;
  assign rise  = rise_q;

endmodule

// File: rtl/quiz_key_debounce.sv
// Input conditioning for the four-player quiz buzzer: four active-low keys
// and the start switch, each debounced into a clean level plus press pulse.
module quiz_key_debounce
  import quiz_pkg::*;
#(
  parameter int CLK_HZ      = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                start_sw,
  output logic [NUM_KEYS-1:0] k,
  output logic [NUM_KEYS-1:0] k_press,
  output logic                start,
  output logic                start_rise
);

  localparam int CNT_MAX = calc_cnt_max(CLK_HZ, DEBOUNCE_MS);

  // Channels are fully independent; simultaneous presses give simultaneous pulses.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_MAX    (CNT_MAX),
      .INVERT     (1'b1)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (key_n[i]),
      .level(k[i]),
      .rise (k_press[i])
    );
  end

  debounce_ch #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_MAX    (CNT_MAX),
    .INVERT     (1'b0)
  ) u_start (
    .clk  (clk),
    .rst  (rst),
    .raw  (start_sw),
    .level(start),
    .rise (start_rise)
  );

endmodule

// File: tb/tb_quiz_key_debounce.sv
// Directed bench for quiz_key_debounce with CNT_MAX = 3 (latency 6 edges).
// Expected values are hand-computed constants; pulses are also tallied per key.
module tb_quiz_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       start_sw = 1'b0;
  logic [3:0] k;
  logic [3:0] k_press;
  logic       start;
  logic       start_rise;

  int checkCount = 0;
  int errorCount = 0;
  int pressTally [4] = '{0, 0, 0, 0};
  int riseTally = 0;
  int snap [4];

  quiz_key_debounce #(
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .start_sw  (start_sw),
    .k         (k),
    .k_press   (k_press),
    .start     (start),
    .start_rise(start_rise)
  );

  always #5 clk = ~clk;

  // Tally pulses on the falling edge so every single-cycle pulse is seen once.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) pressTally[i] += int'(k_press[i]);
    riseTally += int'(start_rise);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] keys, input logic sw);
    key_n    = keys;
    start_sw = sw;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_k"}, 32'(k), 32'h0);
    checkOutput({tag, "_kp"}, 32'(k_press), 32'h0);
    checkOutput({tag, "_st"}, 32'(start), 32'h0);
    checkOutput({tag, "_sr"}, 32'(start_rise), 32'h0);
  endtask

  initial begin
    // Power-on reset.
    #1 rst = 1'b1;
    #1 checkAllZero("por");
    tick(2);
    rst = 1'b0;

    // All keys pressed, then asynchronous reset between edges.
    applyStimulus(4'h0, 1'b0);
    tick(5);
    checkOutput("all_pre", 32'(k), 32'h0);
    tick(1);
    checkOutput("all_k", 32'(k), 32'hF);
    checkOutput("all_kp", 32'(k_press), 32'hF);
    tick(2);
    #3 rst = 1'b1;
    #1 checkAllZero("rst_async");
    tick(3);
    checkAllZero("rst_hold");
    applyStimulus(4'hF, 1'b0);
    rst = 1'b0;
    tick(8);
    checkOutput("rst_after", 32'(k), 32'h0);

    // Clean press on key 2, then release without a pulse.
    for (int i = 0; i < 4; i++) snap[i] = pressTally[i];
    applyStimulus(4'b1011, 1'b0);
    tick(5);
    checkOutput("clean_e5", 32'(k), 32'h0);
    tick(1);
    checkOutput("clean_e6_k", 32'(k), 32'h4);
    checkOutput("clean_e6_kp", 32'(k_press), 32'h4);
    tick(1);
    checkOutput("clean_e7_kp", 32'(k_press), 32'h0);
    tick(4);
    checkOutput("clean_hold", 32'(k), 32'h4);
    applyStimulus(4'hF, 1'b0);
    tick(5);
    checkOutput("clean_rel_e5", 32'(k), 32'h4);
    tick(1);
    checkOutput("clean_rel_e6", 32'(k), 32'h0);
    tick(2);
    checkOutput("clean_cnt", 32'(pressTally[2] - snap[2]), 32'd1);

    // Three-cycle glitch on key 0 must be rejected.
    for (int i = 0; i < 4; i++) snap[i] = pressTally[i];
    applyStimulus(4'b1110, 1'b0);
    tick(3);
    applyStimulus(4'hF, 1'b0);
    tick(8);
    checkOutput("glitch_k", 32'(k), 32'h0);
    checkOutput("glitch_cnt_pulses", 32'(pressTally[0] - snap[0]), 32'd0);
    checkOutput("glitch_cnt_reg", 32'(dut.g_key[0].u_ch.cnt_q), 32'd0);

    // Bounce on key 1 every 2 cycles, settling low in the fifth segment.
    for (int i = 0; i < 4; i++) snap[i] = pressTally[i];
    for (int seg = 0; seg < 4; seg++) begin
      applyStimulus({2'b11, seg[0], 1'b1}, 1'b0);
      tick(2);
    end
    checkOutput("bounce_mid", 32'(k), 32'h0);
    applyStimulus(4'b1101, 1'b0);
    tick(5);
    checkOutput("bounce_e5", 32'(k), 32'h0);
    tick(1);
    checkOutput("bounce_e6_k", 32'(k), 32'h2);
    checkOutput("bounce_e6_kp", 32'(k_press), 32'h2);
    tick(4);
    checkOutput("bounce_once", 32'(pressTally[1] - snap[1]), 32'd1);
    applyStimulus(4'hF, 1'b0);
    tick(8);
    checkOutput("bounce_rel", 32'(k), 32'h0);

    // Simultaneous press of keys 0 and 3, then simultaneous release.
    for (int i = 0; i < 4; i++) snap[i] = pressTally[i];
    applyStimulus(4'b0110, 1'b0);
    tick(6);
    checkOutput("simul_kp", 32'(k_press), 32'h9);
    checkOutput("simul_k", 32'(k), 32'h9);
    tick(1);
    checkOutput("simul_kp_next", 32'(k_press), 32'h0);
    applyStimulus(4'hF, 1'b0);
    tick(5);
    checkOutput("simul_rel_e5", 32'(k), 32'h9);
    tick(1);
    checkOutput("simul_rel_e6", 32'(k), 32'h0);
    checkOutput("simul_rel_kp", 32'(k_press), 32'h0);
    tick(2);
    checkOutput("simul_cnt0", 32'(pressTally[0] - snap[0]), 32'd1);
    checkOutput("simul_cnt3", 32'(pressTally[3] - snap[3]), 32'd1);

    // Start switch raised.
    applyStimulus(4'hF, 1'b1);
    tick(5);
    checkOutput("start_e5", 32'(start), 32'h0);
    tick(1);
    checkOutput("start_e6", 32'(start), 32'h1);
    checkOutput("start_rise_e6", 32'(start_rise), 32'h1);
    tick(1);
    checkOutput("start_rise_e7", 32'(start_rise), 32'h0);
    checkOutput("start_hold", 32'(start), 32'h1);

    // Reset while key 1 is held: fresh press after reset falls.
    applyStimulus(4'b1101, 1'b1);
    tick(8);
    checkOutput("midrst_pre", 32'(k), 32'h2);
    for (int i = 0; i < 4; i++) snap[i] = pressTally[i];
    #2 rst = 1'b1;
    #1 checkAllZero("midrst_async");
    tick(2);
    #2 rst = 1'b0;
    tick(5);
    checkOutput("midrst_e5", 32'(k), 32'h0);
    tick(1);
    checkOutput("midrst_e6_kp", 32'(k_press), 32'h2);
    checkOutput("midrst_e6_k", 32'(k), 32'h2);
    checkOutput("midrst_e6_sr", 32'(start_rise), 32'h1);
    tick(4);
    checkOutput("midrst_once", 32'(pressTally[1] - snap[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
